// File: rtl/act_clip_pipe.sv
// act_clip_pipe: two-stage, multi-lane activation clamp with valid/ready flow
// control. Per beat it applies linear, ReLU, ReLU6 (SIX_Q) or ReLU-N
// (runtime ceiling) to LANES signed words.
//
// S1 holds the raw beat plus its mode and effective ceiling. S2 holds the
// clamped beat and per-lane clipped flags. Both stages use a skid-free
// "advance when downstream empty or draining" rule. This gives full
// throughput and two beats of buffering under backpressure.
//
// Optional build macro: ACT_CLIP_STATS_EN adds stat_clr / stat_hi_cnt. These
// form a saturating count of lanes clipped at the upper bound, and the count
// is taken on every output transfer.
module act_clip_pipe #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter logic signed [DATA_W-1:0] SIX_Q = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [1:0]                in_mode,
  input  logic [DATA_W-1:0]         in_clip_hi,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_clipped
`ifdef ACT_CLIP_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [31:0]               stat_hi_cnt
`endif
);

  localparam logic [1:0] MODE_LIN   = 2'd0;
  localparam logic [1:0] MODE_RELU  = 2'd1;
  localparam logic [1:0] MODE_RELU6 = 2'd2;
  localparam logic [1:0] MODE_RELUN = 2'd3;

  // Stage 1 state
  logic                     s1_valid_q, s1_valid_d;
  logic [LANES*DATA_W-1:0]  s1_data_q,  s1_data_d;
  logic [1:0]               s1_mode_q,  s1_mode_d;
  logic signed [DATA_W-1:0] s1_ceil_q,  s1_ceil_d;

  // Stage 2 state
  logic                     s2_valid_q, s2_valid_d;
  logic [LANES*DATA_W-1:0]  s2_data_q,  s2_data_d;
  logic [LANES-1:0]         s2_clip_q,  s2_clip_d;

  // Handshake and datapath intermediates
  logic                     s1_adv;
  logic                     s2_adv;
  logic                     s1_load;
  logic                     s2_load;
  logic signed [DATA_W-1:0] ceil_eff;
  logic [LANES*DATA_W-1:0]  clamp_data;
  logic [LANES-1:0]         clamp_clip;

`ifdef ACT_CLIP_STATS_EN
  logic [LANES-1:0]         clamp_hi;
  logic [LANES-1:0]         s2_hi_q, s2_hi_d;
  logic [31:0]              stat_q, stat_d;
  logic [32:0]              hi_pop;
  logic [32:0]              cnt_sum;
  logic                     out_xfer;
`endif

  // Advance rules: a stage may take new content when it is empty or when its
  // current content is leaving this cycle. in_ready is purely register-based
  // plus out_ready, never in_valid.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
    s1_load  = s1_adv && in_valid;
    s2_load  = s2_adv && s1_valid_q;
  end

  // Effective ceiling chosen when the beat enters S1. A negative ReLU-N
  // ceiling collapses to zero so every lane of that beat reads 0.
  always_comb begin
    ceil_eff = '0;
    case (in_mode)
      MODE_RELU6: ceil_eff = SIX_Q;
      MODE_RELUN: ceil_eff = in_clip_hi[DATA_W-1] ? '0 : $signed(in_clip_hi);
      default:    ceil_eff = '0;
    endcase
  end

  // S1 next-state: capture beat, mode and ceiling together on acceptance
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_ceil_d  = s1_ceil_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (s1_load) begin
      s1_data_d = in_data;
      s1_mode_d = in_mode;
      s1_ceil_d = ceil_eff;
    end
  end

  // Per-lane clamp of the S1 contents; lanes never interact
  always_comb begin
    logic signed [DATA_W-1:0] lane_x;
    logic signed [DATA_W-1:0] lane_y;
    logic                     lane_hi;
    clamp_data = '0;
    clamp_clip = '0;
`ifdef ACT_CLIP_STATS_EN
    clamp_hi   = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      lane_x  = $signed(s1_data_q[i*DATA_W +: DATA_W]);
      lane_y  = lane_x;
      lane_hi = 1'b0;
      case (s1_mode_q)
        MODE_LIN: begin
          lane_y = lane_x;
        end
        MODE_RELU: begin
          if (lane_x < 0) lane_y = '0;
        end
        default: begin
          if (lane_x < 0) begin
            lane_y = '0;
          end else if (lane_x > s1_ceil_q) begin
            lane_y  = s1_ceil_q;
            lane_hi = 1'b1;
          end
        end
      endcase
      clamp_data[i*DATA_W +: DATA_W] = lane_y;
      clamp_clip[i] = (lane_y != lane_x);
`ifdef ACT_CLIP_STATS_EN
      clamp_hi[i] = lane_hi;
`endif
    end
  end

  // S2 next-state: latch clamp result when S2 drains or is empty
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_clip_d  = s2_clip_q;
`ifdef ACT_CLIP_STATS_EN
    s2_hi_d    = s2_hi_q;
`endif
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      s2_data_d = clamp_data;
      s2_clip_d = clamp_clip;
`ifdef ACT_CLIP_STATS_EN
      s2_hi_d   = clamp_hi;
`endif
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_LIN;
      s1_ceil_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_clip_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_ceil_q  <= s1_ceil_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_clip_q  <= s2_clip_d;
    end
  end

  // Output ports come straight from S2 so they hold while stalled
  always_comb begin
    out_valid   = s2_valid_q;
    out_data    = s2_data_q;
    out_clipped = s2_clip_q;
  end

`ifdef ACT_CLIP_STATS_EN
  // Upper-clip count for the beat leaving S2, saturating at all-ones; clear wins
  always_comb begin
    out_xfer = s2_valid_q && out_ready;
    hi_pop   = '0;
    for (int i = 0; i < LANES; i++) begin
      hi_pop = hi_pop + 33'(s2_hi_q[i]);
    end
    cnt_sum = {1'b0, stat_q} + hi_pop;
    stat_d  = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else if (out_xfer) begin
      stat_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
    stat_hi_cnt = stat_q;
  end

  // Statistics registers, kept beside but apart from the datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_hi_q <= '0;
      stat_q  <= '0;
    end else begin
      s2_hi_q <= s2_hi_d;
      stat_q  <= stat_d;
    end
  end
`else
  // Statistics build disabled: no counter state exists in this configuration.
`endif

endmodule

// File: doc/act_clip_pipe.md
Name: act_clip_pipe

Overview:
Pipelined, multi-lane successor to the combinational ReLU6 clamp. It applies a selectable activation to LANES signed quantized words per beat: linear, ReLU, ReLU6 with a fixed quantized six, or ReLU-N with a runtime ceiling. It sits between the depthwise/pointwise accumulator output and the requantizer. Flow control on both sides is a valid/ready handshake with full throughput and backpressure.

Parameters:
DATA_W, 32, signed lane width in bits.
LANES, 4, number of parallel lanes per beat.
SIX_Q, 6, quantized value of 6.0 used by mode 2 (for Q16.16 this is 6<<16); DATA_W-bit signed.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]; each lane signed
in_mode  in  2  0=linear, 1=ReLU, 2=ReLU6 (SIX_Q), 3=ReLU-N (in_clip_hi)
in_clip_hi  in  DATA_W  signed ceiling for mode 3; sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*DATA_W  clamped lanes, same packing as in_data
out_clipped  out  LANES  per-lane flag: 1 if the lane was changed by the clamp (low or high)

Behaviour:
- Two-stage pipeline. S1 registers data, mode and effective ceiling. S2 registers the clamped result and the clipped flags. Latency is exactly 2 cycles from input handshake to out_valid when out_ready=1.
- Handshake: a transfer occurs when valid&ready are both high.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, with no combinational path from in_valid.
  - Sustains 1 beat/cycle while out_ready=1.
- Stall: while out_ready=0 and out_valid=1, out_data and out_clipped hold stable. Up to 2 beats are buffered, then in_ready falls. No beat is dropped or duplicated.
- Effective ceiling is computed at S1 load:
  - mode 2: SIX_Q.
  - mode 3: in_clip_hi.
  - If the mode-3 ceiling is <0, it is treated as 0, so every lane outputs 0.
- Clamp per lane, signed compare:
  - mode 0: y=x, clipped=0.
  - mode 1: y = x<0 ? 0 : x.
  - modes 2/3: y = x<0 ? 0 : (x>ceil ? ceil : x).
  - clipped=1 iff y!=x.
- Boundaries: x=0 and x=ceil pass unchanged with clipped=0. Most-negative input gives 0. Most-positive input gives ceil. Mode/ceiling changes affect only beats accepted after the change, and are never applied retroactively to in-flight beats.
- Reset:
  - out_valid=0, s1_valid=0, out_data=0, out_clipped=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset mid-stream discards all in-flight beats.
- Lanes are independent; no cross-lane arithmetic. The output width equals the input width, so no growth or rounding.

Optional Feature:
Macro ACT_CLIP_STATS_EN.
- When defined, adds ports stat_clr (in, 1) and stat_hi_cnt (out, 32).
  - stat_hi_cnt counts the lanes clipped at the upper bound in each beat leaving S2 via the out handshake. It adds popcount, range 0..LANES, per transfer.
  - The counter saturates at 32'hFFFFFFFF.
  - stat_clr synchronously zeroes it. If stat_clr coincides with a transfer, the result is 0 (clear wins).
  - Reset value is 0.
- When undefined, these ports and the counter logic are absent. Datapath and timing are identical in both builds.

Test Plan:
- Reset, then mode 2, SIX_Q=6, LANES=4, beat {-5,0,6,7} with out_ready=1 -> out_valid 2 cycles later with {0,0,6,6} and out_clipped=4'b1001.
- Mode 3, in_clip_hi=100, beat {-1,50,100,32'h7FFFFFFF} -> {0,50,100,100}, clipped=4'b1001. Then in_clip_hi=-3 with beat {5,5,5,5} -> {0,0,0,0}, clipped=4'b1111.
- Mode 0 beat {-7,3,-2147483648,9} -> unchanged, clipped=0. Mode 1, same beat -> {0,3,0,9}, clipped=4'b0101.
- Stream 8 beats with out_ready toggling 1,0,0,1 randomly -> in_ready drops after 2 buffered beats. Output sequence matches input order with no loss or duplication, and out_data holds stable while stalled.
- Assert rst with 2 beats in flight -> out_valid=0 next cycle, and the buffered beats never appear. in_ready=1 after reset is released.
- ACT_CLIP_STATS_EN: 3 mode-2 beats of {7,7,0,-1} -> stat_hi_cnt=6. Then stat_clr coinciding with a 4th transfer -> stat_hi_cnt=0.
